// File: rtl/input_conditioner.sv
// Switch/button front end: two-flop synchronisers feeding
// independent debounce FSMs that drive choose, sel_change and step.

module ic_debounce #(
  parameter int W         = 1,
  parameter int DB_CYCLES = 4,
  parameter int CW        = 20
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] smp,
  output logic [W-1:0] stable,
  output logic         commit
);

  typedef enum logic {
    ST_STABLE,
    ST_PENDING
  } state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  stable_q, stable_d;
  logic [W-1:0]  cand_q, cand_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_STABLE;
      stable_q <= '0;
      cand_q   <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      stable_q <= stable_d;
      cand_q   <= cand_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    stable_d = stable_q;
    cand_d   = cand_q;
    cnt_d    = cnt_q;
    commit   = 1'b0;
    unique case (state_q)
      ST_STABLE: begin
        if (smp != stable_q) begin
          if (DB_CYCLES == 1) begin
            stable_d = smp;
            commit   = 1'b1;
          end else begin
            cand_d  = smp;
            cnt_d   = CW'(1);
            state_d = ST_PENDING;
          end
        end
      end
      ST_PENDING: begin
        if (smp == cand_q) begin
          if (cnt_q == CW'(DB_CYCLES - 1)) begin
            stable_d = cand_q;
            commit   = 1'b1;
            state_d  = ST_STABLE;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end else if (smp == stable_q) begin
          state_d = ST_STABLE;
        end else begin
          // a third value restarts the qualification window
          cand_d = smp;
          cnt_d  = CW'(1);
        end
      end
      default: state_d = ST_STABLE;
    endcase
  end

  assign stable = stable_q;

endmodule

module input_conditioner #(
  parameter int DB_CYCLES = 4,
  parameter int CW        = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] sw_raw,
  input  logic       btn_raw,
  output logic [1:0] choose,
  output logic       sel_change,
  output logic       step
);

  logic [1:0] sw_m_q, sw_s_q;
  logic       btn_m_q, btn_s_q;
  logic       sel_change_q, sel_change_d;
  logic       step_q, step_d;
  logic [1:0] sw_stable;
  logic       sw_commit;
  logic       btn_stable;
  logic       btn_commit;

  always_ff @(posedge clk) begin
    if (rst) begin
      sw_m_q       <= '0;
      sw_s_q       <= '0;
      btn_m_q      <= 1'b0;
      btn_s_q      <= 1'b0;
      sel_change_q <= 1'b0;
      step_q       <= 1'b0;
    end else begin
      sw_m_q       <= sw_raw;
      sw_s_q       <= sw_m_q;
      btn_m_q      <= btn_raw;
      btn_s_q      <= btn_m_q;
      sel_change_q <= sel_change_d;
      step_q       <= step_d;
    end
  end

  ic_debounce #(
    .W         (2),
    .DB_CYCLES (DB_CYCLES),
    .CW        (CW)
  ) u_sw_db (
    .clk    (clk),
    .rst    (rst),
    .smp    (sw_s_q),
    .stable (sw_stable),
    .commit (sw_commit)
  );

  ic_debounce #(
    .W         (1),
    .DB_CYCLES (DB_CYCLES),
    .CW        (CW)
  ) u_btn_db (
    .clk    (clk),
    .rst    (rst),
    .smp    (btn_s_q),
    .stable (btn_stable),
    .commit (btn_commit)
  );

  // a commit from a stable 0 is a press; from 1 it is a release
  always_comb begin
    sel_change_d = sw_commit;
    step_d       = btn_commit & ~btn_stable;
  end

  assign choose     = sw_stable;
  assign sel_change = sel_change_q;
  assign step       = step_q;

endmodule

// File: tb/tb_input_conditioner.sv
// Directed and random checks of input_conditioner against a
// run-length model of synchronised samples.

module tb_input_conditioner;

  localparam int DB = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] sw_raw;
  logic       btn_raw;
  logic [1:0] choose;
  logic       sel_change;
  logic       step;

  int total = 0;
  int bad   = 0;
  int n_sel = 0;
  int n_step = 0;

  int s_sw1 = 0, s_sw2 = 0, s_b1 = 0, s_b2 = 0;
  int m_choose = 0, m_bst = 0;
  int sw_last = 0, sw_run = 0, b_last = 0, b_run = 0;
  int m_sel = 0, m_step = 0;

  always #10 clk = ~clk;

  input_conditioner #(
    .DB_CYCLES (DB),
    .CW        (20)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .sw_raw     (sw_raw),
    .btn_raw    (btn_raw),
    .choose     (choose),
    .sel_change (sel_change),
    .step       (step)
  );

  // A value is accepted once it has been the synchronised sample
  // for DB consecutive edges while differing from the accepted one.
  function automatic void model_edge();
    if (rst) begin
      s_sw1 = 0; s_sw2 = 0; s_b1 = 0; s_b2 = 0;
      m_choose = 0; m_bst = 0;
      sw_last = 0; sw_run = 0; b_last = 0; b_run = 0;
      m_sel = 0; m_step = 0;
    end else begin
      m_sel  = 0;
      m_step = 0;
      if (s_sw2 == sw_last && sw_run > 0) begin
        if (sw_run < 1000) sw_run++;
      end else begin
        sw_run = 1;
      end
      sw_last = s_sw2;
      if (sw_last != m_choose && sw_run >= DB) begin
        m_choose = sw_last;
        m_sel    = 1;
      end
      if (s_b2 == b_last && b_run > 0) begin
        if (b_run < 1000) b_run++;
      end else begin
        b_run = 1;
      end
      b_last = s_b2;
      if (b_last != m_bst && b_run >= DB) begin
        m_bst  = b_last;
        m_step = (b_last == 1) ? 1 : 0;
      end
      s_sw2 = s_sw1;
      s_sw1 = int'(sw_raw);
      s_b2  = s_b1;
      s_b1  = int'(btn_raw);
    end
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s got=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("m_choose", 32'(choose), 32'(m_choose));
    chk("m_sel", 32'(sel_change), 32'(m_sel));
    chk("m_step", 32'(step), 32'(m_step));
    n_sel  += int'(sel_change);
    n_step += int'(step);
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  initial begin
    rst     = 1'b1;
    sw_raw  = 2'b11;
    btn_raw = 1'b1;

    // reset with inputs already active
    ticks(2);
    chk("rst_choose", 32'(choose), 32'd0);
    chk("rst_sel", 32'(sel_change), 32'd0);
    chk("rst_step", 32'(step), 32'd0);
    rst = 1'b0;
    n_sel = 0; n_step = 0;
    ticks(5);
    chk("s1_pre", 32'(choose), 32'd0);
    tick();
    chk("s1_choose", 32'(choose), 32'd3);
    chk("s1_sel", 32'(sel_change), 32'd1);
    chk("s1_step", 32'(step), 32'd1);
    ticks(4);
    chk("s1_nsel", 32'(n_sel), 32'd1);
    chk("s1_nstep", 32'(n_step), 32'd1);

    sw_raw = 2'b00; btn_raw = 1'b0;
    ticks(10);

    // switch change 0->2 then 2->3
    n_sel = 0;
    sw_raw = 2'b10;
    ticks(5);
    chk("s2_pre", 32'(choose), 32'd0);
    tick();
    chk("s2_choose", 32'(choose), 32'd2);
    chk("s2_sel", 32'(sel_change), 32'd1);
    tick();
    chk("s2_sel_end", 32'(sel_change), 32'd0);
    ticks(3);
    sw_raw = 2'b11;
    ticks(5);
    chk("s2_pre3", 32'(choose), 32'd2);
    tick();
    chk("s2_choose3", 32'(choose), 32'd3);
    ticks(4);
    chk("s2_nsel", 32'(n_sel), 32'd2);

    // glitch shorter than the window
    sw_raw = 2'b10;
    ticks(10);
    n_sel = 0;
    sw_raw = 2'b01;
    ticks(3);
    sw_raw = 2'b10;
    ticks(10);
    chk("s3_choose", 32'(choose), 32'd2);
    chk("s3_nsel", 32'(n_sel), 32'd0);

    // press, hold, release
    n_step = 0;
    btn_raw = 1'b1;
    ticks(5);
    chk("s4_pre", 32'(step), 32'd0);
    tick();
    chk("s4_step", 32'(step), 32'd1);
    ticks(6);
    btn_raw = 1'b0;
    ticks(10);
    chk("s4_nstep", 32'(n_step), 32'd1);

    // bouncy press
    n_step = 0;
    btn_raw = 1'b1; tick();
    btn_raw = 1'b0; tick();
    btn_raw = 1'b1; tick();
    btn_raw = 1'b0; tick();
    btn_raw = 1'b1;
    ticks(5);
    chk("s5_pre", 32'(step), 32'd0);
    tick();
    chk("s5_step", 32'(step), 32'd1);
    ticks(5);
    chk("s5_nstep", 32'(n_step), 32'd1);
    btn_raw = 1'b0;
    ticks(8);

    // reset interrupts a pending switch change
    sw_raw = 2'b00;
    ticks(8);
    n_sel = 0;
    sw_raw = 2'b11;
    ticks(3);
    rst = 1'b1;
    tick();
    chk("s6_rst_choose", 32'(choose), 32'd0);
    chk("s6_rst_sel", 32'(sel_change), 32'd0);
    rst = 1'b0;
    ticks(5);
    chk("s6_pre", 32'(choose), 32'd0);
    chk("s6_nsel_pre", 32'(n_sel), 32'd0);
    tick();
    chk("s6_choose", 32'(choose), 32'd3);
    chk("s6_sel", 32'(sel_change), 32'd1);
    ticks(4);
    chk("s6_nsel", 32'(n_sel), 32'd1);

    // random holds with occasional reset
    repeat (80) begin
      sw_raw  = 2'($urandom_range(0, 3));
      btn_raw = 1'($urandom_range(0, 1));
      rst     = ($urandom_range(0, 19) == 0);
      ticks($urandom_range(1, 7));
      rst = 1'b0;
    end
    ticks(8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/input_conditioner.md
# input_conditioner

Front-end conditioner for the lab board's slide switches and step button. It synchronises and debounces the raw 2-bit selector switches and the step push-button. It then drives the debounced `choose[1:0]` selector consumed by the display/test datapath stage directly downstream, plus one-cycle `step` and `sel_change` pulses for that stage's control logic. Everything runs in a single clock domain.

## Interface

Parameters:
- `DB_CYCLES`, default 4: number of consecutive identical synchronised samples required to accept a new value. Legal range is 1 to 2^CW−1. Board builds override it to about 1_000_000.
- `CW`, default 20: debounce counter width. Must satisfy 2^CW > DB_CYCLES.

Ports:
- `clk`, in, 1: system clock. All state updates on the rising edge.
- `rst`, in, 1: reset, synchronous and active-high. Sampled on the rising edge of `clk`.
- `sw_raw`, in, 2: raw selector switches. Asynchronous and bouncy.
- `btn_raw`, in, 1: raw step button, active-high. Asynchronous and bouncy.
- `choose`, out, 2: debounced selector value, registered.
- `sel_change`, out, 1: one-cycle pulse when `choose` takes a new value.
- `step`, out, 1: one-cycle pulse on each debounced button press (0→1).

## Operation

Synchroniser:
- Each raw input passes through a two-flop synchroniser (`sw_s[1:0]`, `btn_s`).
- The FSMs see only the synchronised signals.

Debounce FSMs:
- There are two independent instances of the same FSM.
  - Switch channel: the 2-bit vector is treated as one unit.
  - Button channel: 1 bit.
- Each channel holds `stable`, `cand` and `cnt[CW-1:0]`.

State STABLE:
- Sample == `stable`: remain.
- Sample != `stable`: set `cand` = sample, `cnt` = 1, go to PENDING.
- When `DB_CYCLES` = 1, PENDING is skipped. `stable` updates in the same cycle the change is first seen.

State PENDING:
- Sample == `cand` and `cnt` == DB_CYCLES−1: commit.
  - `stable` <= `cand`.
  - Fire the channel pulse.
  - Go to STABLE.
- Sample == `cand` otherwise: `cnt` <= `cnt`+1.
- Sample == `stable`: abandon and go to STABLE. No output change, no pulse.
- Sample is a third value (switch channel only): restart with `cand` = sample and `cnt` = 1.

Outputs:
- `choose` = `stable` of the switch channel.
- `sel_change` is high for exactly the cycle after the switch commit edge. It is registered alongside `choose`, so it is high while the new `choose` value is first visible.
- `step` is high for one cycle after a button commit where the new `stable` = 1. A commit to 0 (release) produces no pulse.
- The two channels are fully independent. `step` and `sel_change` may be high in the same cycle.

Reset:
- Synchroniser flops, `stable`, `cand`, `cnt` clear to 0.
- Both FSMs go to STABLE.
- Outputs reset to `choose` = 2'b00, `sel_change` = 0, `step` = 0.
- Reset asserted mid-PENDING discards the pending value. No pulse is emitted, either during reset or after it.
- A raw input already at a non-zero value when reset deasserts is then debounced normally, with full latency. This gives a switch pulse for any non-zero value, and a `step` pulse for a held button.

## Timing

- Call the first rising edge that samples a new raw level edge 0, with the raw level held constant from then on.
- `sw_s` / `btn_s` show the new level after edge 1.
- With `DB_CYCLES` = N, the commit edge is edge N+1. The new `choose` and its pulse are visible after edge N+1, which is N+1 clocks of latency.
- Default N = 4: output changes after edge 5.
- A raw glitch of N−1 or fewer cycles never reaches `choose`, `step` or `sel_change`.
- Pulses are exactly one clock wide. They cannot repeat without an intervening commit to a different value.
- No combinational path from any input to any output.

## Test plan

All scenarios use `DB_CYCLES` = 4 and a 20 ns clock.

1. Reset: `rst`=1 for 2 cycles with `sw_raw`=2'b11 and `btn_raw`=1.
   - During reset: `choose`=0, `step`=0, `sel_change`=0.
   - After release: `choose`=3 with a `sel_change` pulse, and a `step` pulse, both 5 edges later.
2. Switch change: `sw_raw` 0→2 held for 10 cycles.
   - `choose`=2 after edge 5, `sel_change`=1 for exactly one cycle.
   - Then `sw_raw` 2→3: `choose`=3 five edges later, one more pulse.
3. Switch glitch: `sw_raw` 2→1 for 3 cycles, then back to 2.
   - `choose` stays 2. No `sel_change`.
4. Button press/hold/release: `btn_raw`=1 for 12 cycles, then 0.
   - A single `step` pulse after edge 5 of the press.
   - Nothing further during the hold or on release.
5. Bouncy button: `btn_raw` toggles 1,0,1,0,1 on consecutive cycles, then holds 1.
   - Exactly one `step`, 5 edges after the final rising transition.
6. Reset mid-operation: `sw_raw` 0→3, then `rst`=1 at edge 3 for one cycle, `sw_raw` held at 3.
   - No pulse from the interrupted attempt.
   - `choose`=0 through reset.
   - `choose`=3 with one `sel_change` 5 edges after reset deasserts.
